// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared types and defaults for the AHB-to-APB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

  // Bridge transfer phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // AHB address that maps onto PADDR 0
  localparam logic [31:0] APB_BASE_DEFAULT = 32'h4000D000;

  // Maximum ACCESS cycles before a transfer is forced to complete
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of the ACCESS wait counter (covers TIMEOUT up to 255)
  localparam int WAIT_CNT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module      : apb_wait_timer
// Description : Counts ACCESS cycles of an APB transfer and flags when the
//               count reaches TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer
  import ahb_apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LIMIT   = WAIT_CNT_WIDTH'(TIMEOUT);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_WIDTH-1:0] count_q;
  logic [WAIT_CNT_WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise count up and saturate instead of wrapping
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/ahb_apb_bridge.sv
// ============================================================================
// Module      : ahb_apb_bridge
// Description : Converts single AHB-side requests into APB4 SETUP/ACCESS
//               transfers and returns a one-cycle HREADY completion pulse.
//               A wait timeout and sticky error flag guard against hung
//               peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    APB_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] APB_BASE       = ADDR_WIDTH'(APB_BASE_DEFAULT),
  parameter int                    TIMEOUT        = TIMEOUT_DEFAULT
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [ADDR_WIDTH-1:0]     HADDR,
  input  logic                      HWRITE,
  input  logic [3:0]                HBE,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADY,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic [3:0]                PSTRB,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic                      err_clr,
  output logic                      bridge_err
);

  state_e state_q, state_d;

  logic                      capture;
  logic                      timer_expired;

  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic                      pwrite_q;
  logic [31:0]               pwdata_q;
  logic [3:0]                hbe_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      hready_q;
  logic [31:0]               hrdata_q, hrdata_d;
  logic                      xfer_err_q, xfer_err_d;
  logic                      bridge_err_q, bridge_err_d;

  // Wait counter: zeroed during SETUP so the first ACCESS cycle sees 0
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (HCLK),
    .rst_i     (HRESET),
    .clr_i     (state_q == ST_SETUP),
    .en_i      (state_q == ST_ACCESS),
    .expired_o (timer_expired)
  );

  // Next-state logic; HSEL is only looked at when the bridge can accept work
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (HSEL) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY || timer_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (HSEL) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completion data and error: PREADY has priority over an expiring timer
  always_comb begin
    hrdata_d   = '0;
    xfer_err_d = xfer_err_q;
    if ((state_q == ST_ACCESS) && (state_d == ST_DONE)) begin
      xfer_err_d = PREADY ? PSLVERR : 1'b1;
      if (PREADY && !PSLVERR && !pwrite_q) begin
        hrdata_d = PRDATA;
      end
    end
    bridge_err_d = ((state_q == ST_DONE) && xfer_err_q) || (bridge_err_q && !err_clr);
  end

  // State and registered outputs, all decoded from the upcoming state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      hready_q     <= 1'b0;
      hrdata_q     <= '0;
      xfer_err_q   <= 1'b0;
      bridge_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_q       <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q    <= (state_d == ST_ACCESS);
      hready_q     <= (state_d == ST_DONE);
      hrdata_q     <= hrdata_d;
      xfer_err_q   <= xfer_err_d;
      bridge_err_q <= bridge_err_d;
    end
  end

  // Request capture; these hold steady for the whole APB transfer
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hbe_q    <= '0;
    end else if (capture) begin
      paddr_q  <= APB_ADDR_WIDTH'(HADDR - APB_BASE);
      pwrite_q <= HWRITE;
      pwdata_q <= HWDATA;
      hbe_q    <= HBE;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pwrite_q ? hbe_q : 4'b0000;
  assign HREADY     = hready_q;
  assign HRDATA     = hrdata_q;
  assign bridge_err = bridge_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
// ============================================================================
// Module      : tb_ahb_apb_bridge
// Description : Self-checking bench for ahb_apb_bridge. Transfers are planned
//               on a cycle timeline; a transaction model derives the expected
//               per-cycle outputs, and a compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_apb_bridge;

  localparam int          TMO  = 4;
  localparam logic [31:0] BASE = 32'h4000D000;
  localparam int          MAXC = 160;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [3:0]  HBE = '0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        err_clr = 1'b0;
  logic        bridge_err;

  ahb_apb_bridge #(
    .ADDR_WIDTH     (32),
    .APB_ADDR_WIDTH (12),
    .APB_BASE       (BASE),
    .TIMEOUT        (TMO)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HBE        (HBE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .err_clr    (err_clr),
    .bridge_err (bridge_err)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Per-cycle stimulus plan
  logic        in_hsel   [MAXC];
  logic [31:0] in_haddr  [MAXC];
  logic        in_hwrite [MAXC];
  logic [3:0]  in_hbe    [MAXC];
  logic [31:0] in_hwdata [MAXC];
  logic        in_pready [MAXC];
  logic [31:0] in_prdata [MAXC];
  logic        in_pslverr[MAXC];
  logic        in_errclr [MAXC];

  // Per-cycle expectations
  logic        exp_psel  [MAXC];
  logic        exp_pen   [MAXC];
  logic        exp_hready[MAXC];
  logic [31:0] exp_hrdata[MAXC];
  logic [11:0] exp_paddr [MAXC];
  logic        exp_pwrite[MAXC];
  logic [31:0] exp_pwdata[MAXC];
  logic [3:0]  exp_pstrb [MAXC];
  logic        set_flag  [MAXC];

  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;
  logic model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_cycle(input int c);
    in_hsel[c]    = 1'b0;
    in_haddr[c]   = 32'h0BAD0000 | 32'(c);
    in_hwrite[c]  = 1'b1;
    in_hbe[c]     = 4'hF;
    in_hwdata[c]  = 32'hDEAD0000 | 32'(c);
    in_pready[c]  = 1'b1;
    in_prdata[c]  = 32'hBEEF0000 | 32'(c);
    in_pslverr[c] = 1'b0;
    in_errclr[c]  = 1'b0;
    exp_psel[c]   = 1'b0;
    exp_pen[c]    = 1'b0;
    exp_hready[c] = 1'b0;
    exp_hrdata[c] = '0;
    exp_paddr[c]  = '0;
    exp_pwrite[c] = 1'b0;
    exp_pwdata[c] = '0;
    exp_pstrb[c]  = '0;
    set_flag[c]   = 1'b0;
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) clear_cycle(c);
  endtask

  // Transaction model: a request in cycle c spends one SETUP cycle, then one
  // ACCESS cycle per wait plus the ready cycle (TMO+1 if it times out), then
  // completes in the following cycle.
  task automatic plan(input int c, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input logic slverr);
    logic        to;
    int          na;
    int          done;
    logic [31:0] off;
    to   = (waits > TMO);
    na   = to ? (TMO + 1) : (waits + 1);
    done = c + 2 + na;
    off  = addr - BASE;
    in_hsel[c]   = 1'b1;
    in_haddr[c]  = addr;
    in_hwrite[c] = wr;
    in_hbe[c]    = be;
    in_hwdata[c] = wd;
    for (int k = c + 2; k <= c + 1 + na; k++) in_pready[k] = 1'b0;
    if (!to) begin
      in_pready[c + 1 + na]  = 1'b1;
      in_prdata[c + 1 + na]  = rd;
      in_pslverr[c + 1 + na] = slverr;
    end
    for (int k = c + 1; k <= c + 1 + na; k++) begin
      exp_psel[k]   = 1'b1;
      exp_pen[k]    = (k >= c + 2);
      exp_paddr[k]  = off[11:0];
      exp_pwrite[k] = wr;
      exp_pwdata[k] = wd;
      exp_pstrb[k]  = wr ? be : 4'b0000;
    end
    exp_hready[done] = 1'b1;
    exp_hrdata[done] = (wr || to || slverr) ? 32'h0 : rd;
    set_flag[done]   = to || slverr;
  endtask

  task automatic apply(input int c);
    if (c < MAXC) begin
      HSEL    = in_hsel[c];
      HADDR   = in_haddr[c];
      HWRITE  = in_hwrite[c];
      HBE     = in_hbe[c];
      HWDATA  = in_hwdata[c];
      PREADY  = in_pready[c];
      PRDATA  = in_prdata[c];
      PSLVERR = in_pslverr[c];
      err_clr = in_errclr[c];
    end
  endtask

  task automatic run_until(input int t);
    while (cyc < t) begin
      @(posedge HCLK);
      #1;
      apply(cyc);
    end
  endtask

  task automatic at(input int t);
    run_until(t);
    #3;
  endtask

  // Every-cycle comparison against the model
  always @(negedge HCLK) begin
    if (chk_en && cyc < MAXC) begin
      if (HRESET) begin
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_hready", HREADY, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_err", bridge_err, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb", PSTRB, 0);
        model_err <= 1'b0;
      end else begin
        chk("psel", PSEL, exp_psel[cyc]);
        chk("penable", PENABLE, exp_pen[cyc]);
        chk("hready", HREADY, exp_hready[cyc]);
        chk("bridge_err", bridge_err, model_err);
        if (exp_hready[cyc]) chk("hrdata", HRDATA, exp_hrdata[cyc]);
        if (exp_psel[cyc]) begin
          chk("paddr", PADDR, exp_paddr[cyc]);
          chk("pwrite", PWRITE, exp_pwrite[cyc]);
          chk("pwdata", PWDATA, exp_pwdata[cyc]);
          chk("pstrb", PSTRB, exp_pstrb[cyc]);
        end
        model_err <= set_flag[cyc] | (model_err & ~err_clr);
      end
    end
  end

  initial begin
    int r1, r2, r3, r4, r5, r6, r7;
    clear_from(0);
    chk_en = 1'b1;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    #3;
    chk("reset_psel", PSEL, 0);
    chk("reset_hready", HREADY, 0);
    chk("reset_err", bridge_err, 0);

    // Single read, ready immediately
    r1 = cyc + 2;
    plan(r1, 1'b0, 32'h4000D004, 4'hF, 32'h0, 32'h12345678, 0, 1'b0);
    at(r1 + 1);
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_pen", PENABLE, 0);
    chk("t1_setup_paddr", PADDR, 12'h004);
    chk("t1_pstrb_read", PSTRB, 4'b0000);
    at(r1 + 2);
    chk("t1_access_pen", PENABLE, 1);
    chk("t1_access_paddr", PADDR, 12'h004);
    at(r1 + 3);
    chk("t1_hready", HREADY, 1);
    chk("t1_hrdata", HRDATA, 32'h12345678);
    at(r1 + 4);
    chk("t1_hready_low", HREADY, 0);

    // Write with four wait cycles
    r2 = r1 + 5;
    plan(r2, 1'b1, 32'h4000D010, 4'b0011, 32'hA5A5A5A5, 32'h0, 4, 1'b0);
    at(r2 + 4);
    chk("t2_pwdata", PWDATA, 32'hA5A5A5A5);
    chk("t2_pstrb", PSTRB, 4'b0011);
    at(r2 + 6);
    chk("t2_hready_early", HREADY, 0);
    at(r2 + 7);
    chk("t2_hready", HREADY, 1);

    // Three back-to-back transfers, last one below the base address
    r3 = r2 + 9;
    plan(r3, 1'b0, 32'h4000D020, 4'hF, 32'h0, 32'hCAFEF00D, 0, 1'b0);
    plan(r3 + 3, 1'b1, 32'h4000DFFC, 4'hF, 32'h11223344, 32'h0, 1, 1'b0);
    plan(r3 + 7, 1'b0, 32'h4000CFF8, 4'hF, 32'h0, 32'h0BADCAFE, 0, 1'b0);
    at(r3 + 3);
    chk("t3_hready0", HREADY, 1);
    chk("t3_hrdata0", HRDATA, 32'hCAFEF00D);
    at(r3 + 4);
    chk("t3_b2b_psel", PSEL, 1);
    chk("t3_b2b_pen", PENABLE, 0);
    chk("t3_b2b_paddr", PADDR, 12'hFFC);
    at(r3 + 8);
    chk("t3_wrap_paddr", PADDR, 12'hFF8);
    at(r3 + 10);
    chk("t3_hrdata2", HRDATA, 32'h0BADCAFE);

    // Timeout: PREADY never rises
    r4 = r3 + 12;
    plan(r4, 1'b0, 32'h4000D100, 4'hF, 32'h0, 32'h0, 99, 1'b0);
    in_errclr[r4 + 11] = 1'b1;
    at(r4 + 6);
    chk("t4_hready_early", HREADY, 0);
    at(r4 + 7);
    chk("t4_hready", HREADY, 1);
    chk("t4_hrdata", HRDATA, 32'h0);
    chk("t4_err_not_yet", bridge_err, 0);
    at(r4 + 8);
    chk("t4_err_set", bridge_err, 1);
    at(r4 + 11);
    chk("t4_err_sticky", bridge_err, 1);
    at(r4 + 12);
    chk("t4_err_cleared", bridge_err, 0);

    // Slave error on a read, clear attempted in the DONE cycle
    r5 = r4 + 14;
    plan(r5, 1'b0, 32'h4000D008, 4'hF, 32'h0, 32'h55AA55AA, 1, 1'b1);
    in_errclr[r5 + 4] = 1'b1;
    in_errclr[r5 + 7] = 1'b1;
    at(r5 + 4);
    chk("t5_hready", HREADY, 1);
    chk("t5_hrdata", HRDATA, 32'h0);
    at(r5 + 5);
    chk("t5_set_wins", bridge_err, 1);
    at(r5 + 8);
    chk("t5_err_cleared", bridge_err, 0);

    // Reset in the middle of ACCESS
    r6 = r5 + 10;
    plan(r6, 1'b0, 32'h4000D00C, 4'hF, 32'h0, 32'h77777777, 3, 1'b0);
    run_until(r6 + 3);
    chk("t6_in_access", PENABLE, 1);
    clear_from(r6 + 3);
    #2;
    HRESET = 1'b1;
    #1;
    chk("t6_async_psel", PSEL, 0);
    chk("t6_async_pen", PENABLE, 0);
    chk("t6_async_hready", HREADY, 0);
    run_until(r6 + 5);
    HRESET = 1'b0;

    // Normal traffic after reset
    r7 = r6 + 7;
    plan(r7, 1'b1, 32'h4000D000, 4'b1100, 32'h87654321, 32'h0, 0, 1'b0);
    plan(r7 + 4, 1'b0, 32'h4000D000, 4'hF, 32'h0, 32'h0F0F0F0F, 2, 1'b0);
    at(r7 + 1);
    chk("t7_paddr", PADDR, 12'h000);
    chk("t7_pstrb", PSTRB, 4'b1100);
    chk("t7_pwrite", PWRITE, 1);
    at(r7 + 3);
    chk("t7_hready", HREADY, 1);
    at(r7 + 9);
    chk("t7_hrdata", HRDATA, 32'h0F0F0F0F);
    run_until(r7 + 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-side responder that converts single transfers arriving on the interconnect's slave port 3 (address range 0x4000D000 and up) into APB4 transfers for the UART and other low-speed peripherals. It latches each request, runs the APB SETUP/ACCESS sequence, and returns read data with a one-cycle HREADY completion pulse. A wait-state timeout and a sticky error flag keep a hung peripheral from stalling the bus.

## Interface
- ADDR_WIDTH, 32: AHB address width.
- APB_ADDR_WIDTH, 12: PADDR width.
- APB_BASE, 32'h4000D000: AHB address mapped to PADDR 0.
- TIMEOUT, 255: maximum ACCESS cycles before forced completion; range 1..255.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- HCLK  in  1  clock; all state changes on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the interconnect.
- HADDR  in  ADDR_WIDTH  request address.
- HWRITE  in  1  1 = write.
- HBE  in  4  byte enables.
- HWDATA  in  32  write data, valid in the request cycle.
- HRDATA  out  32  read data, valid while HREADY = 1.
- HREADY  out  1  completion pulse.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB write strobes.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1 each  APB response.
- err_clr  in  1  clears bridge_err.
- bridge_err  out  1  sticky flag: PSLVERR or timeout seen.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - HSEL = 1 means a new request: capture HADDR, HWRITE, HBE and HWDATA, then go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Always moves to ACCESS on the next cycle.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - Wait counter increments each cycle.
  - PREADY = 1: capture PRDATA (reads only) and PSLVERR, then go to DONE.
  - Counter reaches TIMEOUT with PREADY = 0: go to DONE and flag an error.
- **DONE**
  - HREADY = 1 for exactly this cycle.
  - HRDATA = captured data; it is 0 for writes, for errored reads and for timed-out reads.
  - HSEL = 1 in DONE is a new back-to-back request: capture it and go to SETUP. Otherwise go to IDLE.
- HSEL is ignored in SETUP and ACCESS, because the interconnect holds the selected request stable until HREADY.
- Address mapping: PADDR = (HADDR − APB_BASE)[APB_ADDR_WIDTH-1:0]. The subtraction wraps modulo 2^ADDR_WIDTH, with no range check.
- APB outputs:
  - PWRITE = captured HWRITE.
  - PWDATA = captured HWDATA.
  - PSTRB = captured HBE for writes, 4'b0000 for reads.
  - All APB outputs are held constant from SETUP through the last ACCESS cycle.
- bridge_err:
  - Set in DONE when PSLVERR was captured or a timeout occurred.
  - Cleared by err_clr.
  - Set wins over clear when both happen in the same cycle.

## Timing
- Every output is 0 at reset; the state machine is in IDLE with the counter at 0.
- Reset asserted mid-transfer:
  - PSEL and PENABLE drop immediately (asynchronous).
  - No HREADY pulse is produced, and the interrupted transfer is lost.
- Latency with PREADY = 1 in the first ACCESS cycle:
  - Request in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, HREADY in cycle 3.
  - Each PREADY-low cycle adds one cycle.
- Back-to-back throughput: one transfer per 3 cycles.
- Timeout: HREADY arrives in cycle 2 + TIMEOUT + 1 after the request.
- HREADY is never high outside DONE, and never high on two consecutive cycles.
- All outputs are registered except PSTRB, which is decoded from registered state.

## Structure
- Shared package ahb_apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - the APB_BASE default;
  - the TIMEOUT default.
- One natural sub-module, apb_wait_timer:
  - 8-bit counter with clear/enable inputs and an expired output;
  - cleared on entry to ACCESS.

## Test plan
- Read 0x4000D004, PRDATA = 32'h12345678, PREADY = 1 immediately:
  - PADDR = 0x004 in cycles 1–2.
  - HREADY = 1 with HRDATA = 32'h12345678 in cycle 3 only.
- Write 0x4000D010, HWDATA = 32'hA5A5A5A5, HBE = 4'b0011, PREADY low for 4 ACCESS cycles:
  - PWDATA = 32'hA5A5A5A5 and PSTRB = 4'b0011 held stable throughout.
  - HREADY in cycle 7.
- Back-to-back requests, HSEL high again in the DONE cycle:
  - The second transfer's SETUP immediately follows DONE.
  - No IDLE cycle in between.
- PREADY stuck low with TIMEOUT = 4:
  - HREADY arrives 7 cycles after the request with HRDATA = 0.
  - bridge_err goes to 1 and stays 1 until err_clr.
- PSLVERR = 1 on a read:
  - HRDATA = 0 and bridge_err = 1.
  - err_clr asserted in that same DONE cycle leaves bridge_err = 1.
- HRESET asserted during ACCESS:
  - PSEL, PENABLE and HREADY go to 0 immediately.
  - After release, a new request completes normally.
